// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-slot blanking and frame-aligned shadow commit.
// Define SEG_LZ_BLANK_EN to suppress leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000,
   parameter int BLANK  = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic [DIGITS-1:0]     wr_dp,
   output logic                  wr_ready,
   output logic                  frame_start,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(DIGITS);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   act_data;
   logic [4*DIGITS-1:0]   shd_data;
   logic [DIGITS-1:0]     act_dp;
   logic [DIGITS-1:0]     shd_dp;
   logic                  pending;
   logic                  fs_q;
   logic                  boot;
   logic                  slot_end;
   logic                  frame_end;
   logic                  accept;
   logic                  show;
   logic [3:0]            nib;
   logic [DIGITS-1:0]     supp;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

`ifdef SEG_LZ_BLANK_EN
   logic lead;

   // A digit is suppressed only while every higher digit is also a blank zero.
   always_comb begin
      supp = '0;
      lead = 1'b1;
      for (int unsigned i = DIGITS - 1; i > 0; i--) begin
         lead    = lead & (act_data[4*i +: 4] == 4'h0) & ~act_dp[i];
         supp[i] = lead;
      end
   end
`else
   assign supp = '0;
`endif

   assign slot_end  = (cnt == CW'(DIV - 1));
   assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
   assign accept    = wr_en & wr_ready;
   assign nib       = act_data[4*idx +: 4];
   assign show      = (cnt >= CW'(BLANK)) && !supp[idx];

   // The first frame after reset has no preceding wrap edge to register its pulse,
   // so boot covers the cnt=0/idx=0 cycle between reset release and the first edge.
   assign frame_start = fs_q | (boot & rst_n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         act_data <= '0;
         act_dp   <= '0;
         shd_data <= '0;
         shd_dp   <= '0;
         pending  <= 1'b0;
         wr_ready <= 1'b1;
         fs_q     <= 1'b0;
         boot     <= 1'b1;
         an       <= '1;
         seg      <= '1;
      end else begin
         boot <= 1'b0;
         fs_q <= frame_end;

         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (frame_end && pending) begin
            act_data <= shd_data;
            act_dp   <= shd_dp;
         end

         // A write on the wrap edge is only possible with nothing pending, so it
         // simply arms the next commit.
         if (accept) begin
            shd_data <= wr_data;
            shd_dp   <= wr_dp;
            pending  <= 1'b1;
            wr_ready <= 1'b0;
         end else if (frame_end) begin
            pending  <= 1'b0;
            wr_ready <= 1'b1;
         end

         if (show) begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= {~act_dp[idx], hex_seg(nib)};
         end else begin
            an  <= '1;
            seg <= '1;
         end
      end
   end

endmodule
